// File: rtl/shifter_pkg.sv
// Opcode encoding and helpers shared by the barrel shifter and its pipeline stages.
package shifter_pkg;

    localparam logic [2:0] OP_SLL = 3'd0;
    localparam logic [2:0] OP_SRL = 3'd1;
    localparam logic [2:0] OP_SRA = 3'd2;
    localparam logic [2:0] OP_ROL = 3'd3;
    localparam logic [2:0] OP_ROR = 3'd4;

    function automatic logic op_is_valid(input logic [2:0] op);
        return op <= OP_ROR;
    endfunction

endpackage

// File: rtl/pipelined_barrel_shifter_if.sv
// Valid/ready operand and result channels of the pipelined barrel shifter.
interface pipelined_barrel_shifter_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned TAG_W = 4
);
    localparam int unsigned SHW = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [SHW-1:0]   in_shamt;
    logic [2:0]       in_op;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [TAG_W-1:0] out_tag;
    logic             out_zero;
    logic             out_err;

    modport master (
        output in_valid, in_data, in_shamt, in_op, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag, out_zero, out_err
    );

    modport slave (
        input  in_valid, in_data, in_shamt, in_op, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag, out_zero, out_err
    );

endinterface

// File: rtl/shift_stage.sv
// One pipeline level: conditionally shifts/rotates by 2^LEVEL and registers the result
// together with its sideband, under an elastic valid/ready handshake.
module shift_stage import shifter_pkg::*; #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned TAG_W = 4,
    parameter int unsigned LEVEL = 0,
    localparam int unsigned SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             prev_valid,
    input  logic [WIDTH-1:0] prev_data,
    input  logic [SHW-1:0]   prev_shamt,
    input  logic [2:0]       prev_op,
    input  logic             prev_sign,
    input  logic [TAG_W-1:0] prev_tag,
    input  logic             next_ready,
    output logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic [SHW-1:0]   shamt,
    output logic [2:0]       op,
    output logic             sign,
    output logic [TAG_W-1:0] tag
);

    localparam int unsigned AMT = 1 << LEVEL;
    localparam logic [WIDTH-1:0] FillMask = ~({WIDTH{1'b1}} >> AMT);

    logic [WIDTH-1:0] shifted;

    // An empty stage always accepts, so bubbles collapse under a stalled output.
    assign ready = !valid || next_ready;

    always_comb begin
        shifted = prev_data;
        if (prev_shamt[LEVEL]) begin
            case (prev_op)
                OP_SLL:  shifted = prev_data << AMT;
                OP_SRL:  shifted = prev_data >> AMT;
                OP_SRA:  shifted = (prev_data >> AMT) | (prev_sign ? FillMask : '0);
                OP_ROL:  shifted = (prev_data << AMT) | (prev_data >> (WIDTH - AMT));
                OP_ROR:  shifted = (prev_data >> AMT) | (prev_data << (WIDTH - AMT));
                default: shifted = prev_data;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
            shamt <= '0;
            op    <= '0;
            sign  <= 1'b0;
            tag   <= '0;
        end else if (ready) begin
            valid <= prev_valid;
            if (prev_valid) begin
                data  <= shifted;
                shamt <= prev_shamt;
                op    <= prev_op;
                sign  <= prev_sign;
                tag   <= prev_tag;
            end
        end
    end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter: one log2 shift level per stage, SHW stages, tag carried alongside.
module pipelined_barrel_shifter import shifter_pkg::*; #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned TAG_W = 4
) (
    input logic clk,
    input logic rst_n,
    pipelined_barrel_shifter_if.slave bus
);

    localparam int unsigned SHW = $clog2(WIDTH);

    // Index k is the input of stage k; index SHW is the final register.
    logic             valid_c [SHW+1];
    logic             ready_c [SHW+1];
    logic [WIDTH-1:0] data_c  [SHW+1];
    logic [SHW-1:0]   shamt_c [SHW+1];
    logic [2:0]       op_c    [SHW+1];
    logic             sign_c  [SHW+1];
    logic [TAG_W-1:0] tag_c   [SHW+1];

    assign valid_c[0] = bus.in_valid;
    assign data_c[0]  = bus.in_data;
    assign shamt_c[0] = bus.in_shamt;
    assign op_c[0]    = bus.in_op;
    assign sign_c[0]  = bus.in_data[WIDTH-1];
    assign tag_c[0]   = bus.in_tag;

    assign ready_c[SHW] = bus.out_ready;
    assign bus.in_ready = ready_c[0];

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        shift_stage #(
            .WIDTH (WIDTH),
            .TAG_W (TAG_W),
            .LEVEL (k)
        ) u_stage (
            .clk        (clk),
            .rst_n      (rst_n),
            .prev_valid (valid_c[k]),
            .prev_data  (data_c[k]),
            .prev_shamt (shamt_c[k]),
            .prev_op    (op_c[k]),
            .prev_sign  (sign_c[k]),
            .prev_tag   (tag_c[k]),
            .next_ready (ready_c[k+1]),
            .ready      (ready_c[k]),
            .valid      (valid_c[k+1]),
            .data       (data_c[k+1]),
            .shamt      (shamt_c[k+1]),
            .op         (op_c[k+1]),
            .sign       (sign_c[k+1]),
            .tag        (tag_c[k+1])
        );
    end

    assign bus.out_valid = valid_c[SHW];
    assign bus.out_data  = data_c[SHW];
    assign bus.out_tag   = tag_c[SHW];
    assign bus.out_zero  = valid_c[SHW] && (data_c[SHW] == '0);
    assign bus.out_err   = valid_c[SHW] && !op_is_valid(op_c[SHW]);

    // Shift amount and sign are fully consumed by the last stage.
    logic unused_tail;
    assign unused_tail = ^{shamt_c[SHW], sign_c[SHW]};

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Self-checking bench: directed vectors plus a queue-based reference model of the shifter.
module tb_pipelined_barrel_shifter;

    localparam int W   = 8;
    localparam int TW  = 4;
    localparam int SHW = 3;

    typedef struct packed {
        logic [W-1:0]  data;
        logic [TW-1:0] tag;
        logic          err;
    } exp_t;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;
    int   out_count;
    exp_t q[$];

    pipelined_barrel_shifter_if #(.WIDTH(W), .TAG_W(TW)) bus ();

    pipelined_barrel_shifter #(
        .WIDTH (W),
        .TAG_W (TW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain arithmetic, rotates one bit at a time.
    function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] d,
                                   input logic [SHW-1:0] s, input logic [TW-1:0] tag);
        exp_t e;
        logic [W-1:0] r;
        r = d;
        e.err = 1'b0;
        case (op)
            3'd0: r = d << s;
            3'd1: r = d >> s;
            3'd2: r = $signed(d) >>> s;
            3'd3: for (int i = 0; i < int'(s); i++) r = {r[W-2:0], r[W-1]};
            3'd4: for (int i = 0; i < int'(s); i++) r = {r[0], r[W-1:1]};
            default: begin
                r = d;
                e.err = 1'b1;
            end
        endcase
        e.data = r;
        e.tag  = tag;
        return e;
    endfunction

    // Scoreboard: sampled mid-cycle, when both sides of every handshake are stable.
    logic          held_v;
    logic [W-1:0]  held_data;
    logic [TW-1:0] held_tag;
    logic          held_zero;
    logic          held_err;

    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            held_v = 1'b0;
        end else begin
            if (bus.out_valid) begin
                if (q.size() == 0) begin
                    check("sb_unexpected_out", 1, 0);
                end else begin
                    check("sb_data", int'(bus.out_data), int'(q[0].data));
                    check("sb_tag", int'(bus.out_tag), int'(q[0].tag));
                    check("sb_err", int'(bus.out_err), int'(q[0].err));
                    check("sb_zero", int'(bus.out_zero), int'(q[0].data == '0));
                end
                if (held_v) begin
                    check("hold_data", int'(bus.out_data), int'(held_data));
                    check("hold_tag", int'(bus.out_tag), int'(held_tag));
                    check("hold_zero", int'(bus.out_zero), int'(held_zero));
                    check("hold_err", int'(bus.out_err), int'(held_err));
                end
            end
            held_v    = bus.out_valid && !bus.out_ready;
            held_data = bus.out_data;
            held_tag  = bus.out_tag;
            held_zero = bus.out_zero;
            held_err  = bus.out_err;
            if (bus.out_valid && bus.out_ready && q.size() > 0) begin
                void'(q.pop_front());
                out_count++;
            end
            if (bus.in_valid && bus.in_ready)
                q.push_back(model(bus.in_op, bus.in_data, bus.in_shamt, bus.in_tag));
        end
    end

    task automatic drive(input logic [2:0] op, input logic [W-1:0] d, input logic [SHW-1:0] s,
                         input logic [TW-1:0] tag);
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_data  = d;
        bus.in_shamt = s;
        bus.in_tag   = tag;
    endtask

    task automatic run_one(input string name, input logic [2:0] op, input logic [W-1:0] d,
                           input logic [SHW-1:0] s, input logic [TW-1:0] tag,
                           input logic [W-1:0] exp_d, input logic exp_z, input logic exp_e);
        int n;
        @(posedge clk); #1;
        drive(op, d, s, tag);
        n = 0;
        while (!bus.in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_latency"}, n, SHW - 1);
        check({name, "_data"}, int'(bus.out_data), int'(exp_d));
        check({name, "_tag"}, int'(bus.out_tag), int'(tag));
        check({name, "_zero"}, int'(bus.out_zero), int'(exp_z));
        check({name, "_err"}, int'(bus.out_err), int'(exp_e));
    endtask

    logic [2:0]     st_op    [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd2, 3'd7};
    logic [W-1:0]   st_data  [8] = '{8'h12, 8'hF0, 8'h80, 8'h5A, 8'hC3, 8'h77, 8'h40, 8'h01};
    logic [SHW-1:0] st_shamt [8] = '{3'd1, 3'd4, 3'd3, 3'd2, 3'd5, 3'd6, 3'd7, 3'd0};
    logic [2:0]     bp_op    [4] = '{3'd0, 3'd3, 3'd2, 3'd1};
    logic [W-1:0]   bp_data  [4] = '{8'h0F, 8'h81, 8'hC0, 8'h55};
    logic [SHW-1:0] bp_shamt [4] = '{3'd4, 3'd2, 3'd1, 3'd3};

    initial begin
        logic [11:0] ov;
        logic [4:0]  rd;
        logic [3:0]  stale;
        int          k;
        int          base;
        tests = 0;
        fails = 0;
        out_count = 0;
        held_v = 1'b0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.in_shamt = '0;
        bus.in_op = '0;
        bus.in_tag = '0;
        bus.out_ready = 1'b1;
        #1;
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_out_data", int'(bus.out_data), 0);
        check("rst_out_tag", int'(bus.out_tag), 0);
        check("rst_out_zero", int'(bus.out_zero), 0);
        check("rst_out_err", int'(bus.out_err), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", int'(bus.in_ready), 1);

        run_one("sll96_3", 3'd0, 8'h96, 3'd3, 4'h5, 8'hB0, 1'b0, 1'b0);
        run_one("sra96_2", 3'd2, 8'h96, 3'd2, 4'h1, 8'hE5, 1'b0, 1'b0);
        run_one("srl96_2", 3'd1, 8'h96, 3'd2, 4'h2, 8'h25, 1'b0, 1'b0);
        run_one("sra7f_7", 3'd2, 8'h7F, 3'd7, 4'h3, 8'h00, 1'b1, 1'b0);
        run_one("sra80_7", 3'd2, 8'h80, 3'd7, 4'h4, 8'hFF, 1'b0, 1'b0);
        run_one("ror96_3", 3'd4, 8'h96, 3'd3, 4'h6, 8'hD2, 1'b0, 1'b0);
        run_one("rol81_1", 3'd3, 8'h81, 3'd1, 4'h7, 8'h03, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++)
            run_one($sformatf("zero_shamt_op%0d", i), 3'(i), 8'hA5, 3'd0, 4'(i), 8'hA5, 1'b0,
                    1'b0);
        run_one("op6_3c", 3'd6, 8'h3C, 3'd5, 4'hE, 8'h3C, 1'b0, 1'b1);

        // Backpressure: pipeline fills, then in_ready drops; output must hold.
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        base = out_count;
        k = 0;
        for (int c = 0; c < 5; c++) begin
            drive(bp_op[k], bp_data[k], bp_shamt[k], 4'(8 + k));
            rd[c] = bus.in_ready;
            @(posedge clk); #1;
            if (rd[c]) k++;
        end
        check("bp_in_ready_pattern", int'(rd), 32'h07);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("bp_drain_count", out_count - base, 3);
        check("bp_queue_empty", q.size(), 0);

        // Back-to-back stream with in_valid held high.
        base = out_count;
        for (int c = 0; c < 12; c++) begin
            if (c < 8) drive(st_op[c], st_data[c], st_shamt[c], 4'(c));
            else bus.in_valid = 1'b0;
            @(posedge clk); #1;
            ov[c] = bus.out_valid;
        end
        check("stream_valid_pattern", int'(ov), 32'h3FC);
        check("stream_count", out_count - base, 8);

        // Reset with two operations in flight.
        drive(3'd0, 8'h11, 3'd1, 4'h9);
        @(posedge clk); #1;
        drive(3'd1, 8'h88, 3'd2, 4'hA);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_pre_valid", int'(bus.out_valid), 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_async_valid", int'(bus.out_valid), 0);
        check("mid_rst_async_data", int'(bus.out_data), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            stale[c] = bus.out_valid;
        end
        check("mid_rst_no_stale", int'(stale), 0);
        run_one("post_rst_sll", 3'd0, 8'h01, 3'd7, 4'hB, 8'h80, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d",
                 tests, fails);
        $fatal(1, "timeout");
    end

endmodule
